sdram_arbit: RTL

Command-bus arbiter for the SDRAM controller. Sits between the four command sources (`sdram_init`, auto-refresh, write, read) and the SDRAM pins. Holds the bus for initialization until `init_end`, then grants the bus to one requester at a time:

- auto-refresh has fixed highest priority;
- write and read alternate when both are pending.

It multiplexes the granted source's command, bank, address and write data onto the device pins, and drives NOP between operations.

---
 rtl/sdram_pkg.sv | 25 ++
 rtl/sdram_arbit.sv | 122 ++++++++++++
 2 files changed

// File: rtl/sdram_pkg.sv
// Shared SDRAM definitions: command encodings, arbiter states and default bus widths.
// A command is {cs_n, ras_n, cas_n, we_n}.
package sdram_pkg;

    localparam int SDRAM_ADDR_W = 13;
    localparam int SDRAM_BA_W   = 2;
    localparam int SDRAM_DATA_W = 16;

    localparam logic [3:0] CMD_NOP       = 4'b0111;
    localparam logic [3:0] CMD_PRECHARGE = 4'b0010;
    localparam logic [3:0] CMD_AUTO_REF  = 4'b0001;
    localparam logic [3:0] CMD_LOAD_MODE = 4'b0000;
    localparam logic [3:0] CMD_ACTIVE    = 4'b0011;
    localparam logic [3:0] CMD_WRITE     = 4'b0100;
    localparam logic [3:0] CMD_READ      = 4'b0101;

    typedef enum logic [2:0] {
        ST_INIT,
        ST_ARBIT,
        ST_AREF,
        ST_WRITE,
        ST_READ
    } arb_state_e;

endpackage

// File: rtl/sdram_arbit.sv
// SDRAM command-bus arbiter: holds the bus for init, then grants refresh (highest
// priority), write or read one at a time and muxes the owner onto the device pins.
module sdram_arbit
    import sdram_pkg::*;
#(
    parameter int ADDR_W = SDRAM_ADDR_W,
    parameter int BA_W   = SDRAM_BA_W,
    parameter int DATA_W = SDRAM_DATA_W
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    input  logic [3:0]        init_cmd,
    input  logic [BA_W-1:0]   init_ba,
    input  logic [ADDR_W-1:0] init_addr,
    input  logic              init_end,
    input  logic              aref_req,
    input  logic              aref_end,
    input  logic [3:0]        aref_cmd,
    input  logic [BA_W-1:0]   aref_ba,
    input  logic [ADDR_W-1:0] aref_addr,
    input  logic              wr_req,
    input  logic              wr_end,
    input  logic [3:0]        wr_cmd,
    input  logic [BA_W-1:0]   wr_ba,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic              wr_sdram_en,
    input  logic [DATA_W-1:0] wr_sdram_data,
    input  logic              rd_req,
    input  logic              rd_end,
    input  logic [3:0]        rd_cmd,
    input  logic [BA_W-1:0]   rd_ba,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              aref_en,
    output logic              wr_en,
    output logic              rd_en,
    output logic [DATA_W-1:0] rd_sdram_data,
    output logic              sdram_cke,
    output logic              sdram_cs_n,
    output logic              sdram_ras_n,
    output logic              sdram_cas_n,
    output logic              sdram_we_n,
    output logic [BA_W-1:0]   sdram_ba,
    output logic [ADDR_W-1:0] sdram_addr,
    inout  wire  [DATA_W-1:0] sdram_dq
);

    arb_state_e state_q, state_d;
    logic       last_wr_q, last_wr_d;
    logic [3:0] cmd_mux;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q   <= ST_INIT;
            last_wr_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            last_wr_q <= last_wr_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        last_wr_d = last_wr_q;
        case (state_q)
            ST_INIT:  if (init_end) state_d = ST_ARBIT;
            ST_ARBIT: begin
                // last_wr breaks the write/read tie so neither can starve the other
                if (aref_req)                state_d = ST_AREF;
                else if (wr_req && rd_req)   state_d = last_wr_q ? ST_READ : ST_WRITE;
                else if (wr_req)             state_d = ST_WRITE;
                else if (rd_req)             state_d = ST_READ;
                if (state_d == ST_WRITE)     last_wr_d = 1'b1;
                else if (state_d == ST_READ) last_wr_d = 1'b0;
            end
            ST_AREF:  if (aref_end) state_d = ST_ARBIT;
            ST_WRITE: if (wr_end)   state_d = ST_ARBIT;
            ST_READ:  if (rd_end)   state_d = ST_ARBIT;
            default:  state_d = ST_INIT;
        endcase
    end

    always_comb begin
        aref_en = (state_q == ST_AREF);
        wr_en   = (state_q == ST_WRITE);
        rd_en   = (state_q == ST_READ);
    end

    always_comb begin
        cmd_mux    = CMD_NOP;
        sdram_ba   = {BA_W{1'b1}};
        sdram_addr = {ADDR_W{1'b1}};
        case (state_q)
            ST_INIT: begin
                cmd_mux    = init_cmd;
                sdram_ba   = init_ba;
                sdram_addr = init_addr;
            end
            ST_AREF: begin
                cmd_mux    = aref_cmd;
                sdram_ba   = aref_ba;
                sdram_addr = aref_addr;
            end
            ST_WRITE: begin
                cmd_mux    = wr_cmd;
                sdram_ba   = wr_ba;
                sdram_addr = wr_addr;
            end
            ST_READ: begin
                cmd_mux    = rd_cmd;
                sdram_ba   = rd_ba;
                sdram_addr = rd_addr;
            end
            default: ;
        endcase
    end

    assign {sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n} = cmd_mux;
    assign sdram_cke     = 1'b1;
    assign sdram_dq      = (state_q == ST_WRITE && wr_sdram_en) ? wr_sdram_data : {DATA_W{1'bz}};
    assign rd_sdram_data = sdram_dq;

endmodule
